// File: rtl/dc_fu_line_fetch_ctrl.sv
// Fetch-unit line front end: turns one texture-line request into AXI4 INCR AR bursts and tracks R-last returns.
// Optional macro DC_FU_LINE_FETCH_4K_SPLIT_EN additionally clips each burst at the next 4 KiB boundary.
module dc_fu_line_fetch_ctrl #(
    parameter int LINE_NUMBER_WIDTH     = 11,
    parameter int AXI_ARADDR_WIDTH      = 32,
    parameter int PIXELS_PER_LINE_WIDTH = 11,
    parameter int AXI_DATA_BYTES        = 8,
    parameter int BYTES_PER_PIXEL       = 4,
    parameter int MAX_BURST_LEN         = 16,
    parameter int MAX_OUTSTANDING       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [LINE_NUMBER_WIDTH-1:0]     line_number,
    input  logic                             line_data_valid,
    output logic                             line_data_ready,
    input  logic [AXI_ARADDR_WIDTH-1:0]      frame_addr,
    input  logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line,
    output logic [AXI_ARADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                       m_axi_arlen,
    output logic [2:0]                       m_axi_arsize,
    output logic [1:0]                       m_axi_arburst,
    output logic                             m_axi_arvalid,
    input  logic                             m_axi_arready,
    input  logic                             m_axi_rvalid,
    input  logic                             m_axi_rready,
    input  logic                             m_axi_rlast,
    output logic                             line_busy,
    output logic                             line_done
);
    localparam int AW = AXI_ARADDR_WIDTH;
    localparam int LB = $clog2(AXI_DATA_BYTES);
    localparam int RW = PIXELS_PER_LINE_WIDTH + $clog2(BYTES_PER_PIXEL) + 1;
    localparam int BW = RW + LB;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN} state_e;

    state_e                           state_q, state_d;
    logic [LINE_NUMBER_WIDTH-1:0]     line_q, line_d;
    logic [AW-1:0]                    frame_q, frame_d;
    logic [PIXELS_PER_LINE_WIDTH-1:0] ppl_q, ppl_d;
    logic [AW-1:0]                    addr_q, addr_d;
    logic [RW-1:0]                    rem_q, rem_d;
    logic [OW-1:0]                    outst_q, outst_d;
    logic                             arvalid_q, arvalid_d;
    logic [7:0]                       arlen_q, arlen_d;

    logic          ar_fire, r_fire;
    logic [BW-1:0] bytes_w;
    logic [RW-1:0] stride_w;
    logic [31:0]   burst_w;
`ifdef DC_FU_LINE_FETCH_4K_SPLIT_EN
    logic [31:0]   to4k_w;
`endif

    assign ar_fire  = arvalid_q & m_axi_arready;
    assign r_fire   = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign bytes_w  = BW'(ppl_q) * BW'(BYTES_PER_PIXEL) + BW'(AXI_DATA_BYTES - 1);
    assign stride_w = RW'(bytes_w >> LB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S_IDLE:  if (line_data_valid) state_d = S_CALC;
                S_CALC:  state_d = (stride_w == '0) ? S_DRAIN : S_ISSUE;
                S_ISSUE: if (rem_d == '0) state_d = S_DRAIN;
                S_DRAIN: if (outst_q == '0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        line_data_ready = (state_q == S_IDLE) && !rst;
        line_busy       = (state_q != S_IDLE);
        line_done       = (state_q == S_DRAIN) && (outst_q == '0) && en;
    end

    always_comb begin
        line_d    = line_q;
        frame_d   = frame_q;
        ppl_d     = ppl_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        outst_d   = outst_q;
        arvalid_d = arvalid_q & ~m_axi_arready;
        arlen_d   = arlen_q;
        burst_w   = '0;

        if (state_q == S_IDLE && line_data_valid && en) begin
            line_d  = line_number;
            frame_d = frame_addr;
            ppl_d   = pixels_per_line;
        end
        if (state_q == S_CALC && en) begin
            addr_d = (frame_q & ~AW'(AXI_DATA_BYTES - 1))
                   + ((AW'(line_q) * AW'(stride_w)) << LB);
            rem_d  = stride_w;
        end
        // AR/R bookkeeping runs regardless of en so in-flight handshakes are never lost
        if (ar_fire) begin
            addr_d = addr_q + ((AW'(arlen_q) + AW'(1)) << LB);
            rem_d  = rem_q - (RW'(arlen_q) + RW'(1));
        end
        if (ar_fire && !r_fire)
            outst_d = outst_q + OW'(1);
        else if (!ar_fire && r_fire && outst_q != '0)
            outst_d = outst_q - OW'(1);

        burst_w = (32'(rem_d) < 32'(MAX_BURST_LEN)) ? 32'(rem_d) : 32'(MAX_BURST_LEN);
`ifdef DC_FU_LINE_FETCH_4K_SPLIT_EN
        to4k_w = (32'd4096 - {20'd0, addr_d[11:0]}) >> LB;
        if (to4k_w < burst_w) burst_w = to4k_w;
`endif
        // Burst parameters are registered together with arvalid and frozen until arready
        if (!arvalid_d && en && state_q == S_ISSUE && rem_d != '0
            && outst_d < OW'(MAX_OUTSTANDING)) begin
            arvalid_d = 1'b1;
            arlen_d   = 8'(burst_w - 32'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q    <= '0;
            frame_q   <= '0;
            ppl_q     <= '0;
            addr_q    <= '0;
            rem_q     <= '0;
            outst_q   <= '0;
            arvalid_q <= 1'b0;
            arlen_q   <= '0;
        end else begin
            line_q    <= line_d;
            frame_q   <= frame_d;
            ppl_q     <= ppl_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            outst_q   <= outst_d;
            arvalid_q <= arvalid_d;
            arlen_q   <= arlen_d;
        end
    end

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arsize  = 3'(LB);
    assign m_axi_arburst = 2'b01;
endmodule

// File: tb/tb_dc_fu_line_fetch_ctrl.sv
// Bench for dc_fu_line_fetch_ctrl: randomized AXI slave plus a burst-plan model computed from line geometry.
module tb_dc_fu_line_fetch_ctrl;
    localparam int DB = 8, BPP = 4, MBL = 16, MO = 4;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [10:0] line_number;
    logic        line_data_valid, line_data_ready;
    logic [31:0] frame_addr;
    logic [10:0] pixels_per_line;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
    logic        line_busy, line_done;

    dc_fu_line_fetch_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .line_number(line_number), .line_data_valid(line_data_valid),
        .line_data_ready(line_data_ready), .frame_addr(frame_addr),
        .pixels_per_line(pixels_per_line),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rlast(m_axi_rlast), .line_busy(line_busy), .line_done(line_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    logic [31:0] exp_addr[$];
    int          exp_len[$];
    int          pend[$];
    int tb_outst = 0, ar_cnt = 0, done_cnt = 0, a0 = 0, d0 = 0, nexp = 0;
    bit auto_drv = 1'b0;
    int ar_prob = 100, r_prob = 100, rr_prob = 100, en_prob = 100;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Burst plan straight from line geometry: beats, base address, then greedy split
    function automatic int plan_line(input int unsigned line, input logic [31:0] frame,
                                     input int unsigned ppl);
        int unsigned beats, rem, n;
        logic [31:0] a;
        int cnt = 0;
        beats = (ppl * BPP + DB - 1) / DB;
        a = (frame & ~32'(DB - 1)) + 32'(line * beats * DB);
        rem = beats;
        while (rem > 0) begin
            n = (rem < MBL) ? rem : MBL;
`ifdef DC_FU_LINE_FETCH_4K_SPLIT_EN
            if ((4096 - (a % 4096)) / DB < n) n = (4096 - (a % 4096)) / DB;
`endif
            exp_addr.push_back(a);
            exp_len.push_back(int'(n) - 1);
            a = a + 32'(n * DB);
            rem = rem - n;
            cnt++;
        end
        return cnt;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (line_done) begin
                done_cnt++;
                chk("done_outstanding", 32'(tb_outst), 0);
                chk("done_ar_left", 32'(exp_addr.size()), 0);
            end
            if (m_axi_arvalid && m_axi_arready) begin
                chk("ar_outst_limit", 32'(tb_outst < MO), 1);
                chk("ar_expected", 32'(exp_addr.size() != 0), 1);
                if (exp_addr.size() != 0) begin
                    chk("araddr", m_axi_araddr, exp_addr.pop_front());
                    chk("arlen", 32'(m_axi_arlen), 32'(exp_len.pop_front()));
                end
                pend.push_back(int'(m_axi_arlen) + 1);
                tb_outst++;
                ar_cnt++;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                if (m_axi_rlast) begin
                    if (pend.size() != 0) void'(pend.pop_front());
                    if (tb_outst > 0) tb_outst--;
                end else if (pend.size() != 0) begin
                    pend[0] = pend[0] - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (auto_drv) begin
            m_axi_arready = ($urandom_range(0, 99) < ar_prob);
            m_axi_rvalid  = (pend.size() != 0) && ($urandom_range(0, 99) < r_prob);
            m_axi_rlast   = (pend.size() != 0) && (pend[0] == 1);
            m_axi_rready  = ($urandom_range(0, 99) < rr_prob);
            en            = ($urandom_range(0, 99) < en_prob);
        end
    end

    task automatic start_line(input int unsigned line, input logic [31:0] frame,
                              input int unsigned ppl);
        int k = 0;
        nexp = plan_line(line, frame, ppl);
        a0 = ar_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        line_number = 11'(line); frame_addr = frame; pixels_per_line = 11'(ppl);
        line_data_valid = 1'b1;
        do begin @(negedge clk); k++; end while (!(line_data_ready && en) && k < 2000);
        chk("accept", 32'(line_data_ready && en), 1);
        @(posedge clk); #1;
        line_data_valid = 1'b0;
    endtask

    task automatic wait_line();
        int k = 0;
        while (done_cnt == d0 && k < 20000) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_cnt - d0), 1);
        chk("ar_count", 32'(ar_cnt - a0), 32'(nexp));
        chk("ar_plan_left", 32'(exp_addr.size()), 0);
    endtask

    task automatic run_line(input int unsigned line, input logic [31:0] frame,
                            input int unsigned ppl);
        start_line(line, frame, ppl);
        wait_line();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; en = 1'b0; line_data_valid = 1'b0; line_number = '0;
        frame_addr = '0; pixels_per_line = '0; m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_rready = 1'b0; m_axi_rlast = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(line_data_ready), 0);
        chk("rst_arvalid", 32'(m_axi_arvalid), 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_arlen", 32'(m_axi_arlen), 0);
        chk("rst_busy", 32'(line_busy), 0);
        chk("rst_done", 32'(line_done), 0);
        chk("arsize", 32'(m_axi_arsize), 3);
        chk("arburst", 32'(m_axi_arburst), 1);
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(line_data_ready), 1);

        // stray R-last with nothing outstanding must not disturb the counter
        @(posedge clk); #1;
        m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1;
        @(posedge clk); #1;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        @(negedge clk);
        auto_drv = 1'b1;

        run_line(3, 32'h1000_0000, 640);
        chk("t1_ar20", 32'(nexp), 20);
        run_line(0, 32'h2000_0000, 20);

        // zero-length line: done exactly two cycles after the accept cycle
        @(posedge clk); #1;
        pixels_per_line = '0; line_data_valid = 1'b1;
        a0 = ar_cnt; d0 = done_cnt;
        @(negedge clk);
        chk("z_accept", 32'(line_data_ready), 1);
        @(posedge clk); #1;
        line_data_valid = 1'b0;
        @(negedge clk);
        chk("z_done_cyc1", 32'(line_done), 0);
        chk("z_busy", 32'(line_busy), 1);
        @(negedge clk);
        chk("z_done_cyc2", 32'(line_done), 1);
        @(negedge clk);
        chk("z_done_pulse", 32'(line_done), 0);
        chk("z_ready", 32'(line_data_ready), 1);
        chk("z_no_ar", 32'(ar_cnt - a0), 0);

        // outstanding limit: no R returns, only MO bursts go out
        r_prob = 0;
        start_line(3, 32'h1000_0000, 640);
        repeat (20) @(negedge clk);
        chk("t3_ar4", 32'(ar_cnt - a0), 4);
        chk("t3_arvalid_low", 32'(m_axi_arvalid), 0);
        auto_drv = 1'b0;
        @(posedge clk); #1;
        m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rready = 1'b1; m_axi_rlast = 1'b1;
        @(posedge clk); #1;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        @(negedge clk);
        chk("t3_5th_ar", 32'(m_axi_arvalid), 1);
        auto_drv = 1'b1; r_prob = 100;
        wait_line();

        run_line(0, 32'h1000_0FC0, 640);

        // AR held under backpressure while en toggles
        auto_drv = 1'b0;
        @(posedge clk); #1;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; en = 1'b1;
        start_line(5, 32'h0040_0000, 640);
        k = 0;
        do begin @(negedge clk); k++; end while (!m_axi_arvalid && k < 20);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            en = i[0];
            @(negedge clk);
            chk("t5_arvalid_held", 32'(m_axi_arvalid), 1);
            chk("t5_araddr_held", m_axi_araddr, exp_addr[0]);
            chk("t5_arlen_held", 32'(m_axi_arlen), 32'(exp_len[0]));
        end
        @(posedge clk); #1;
        m_axi_arready = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        m_axi_arready = 1'b0;
        @(negedge clk);
        chk("t5_no_new_ar_en0", 32'(m_axi_arvalid), 0);
        chk("t5_one_fire", 32'(ar_cnt - a0), 1);
        auto_drv = 1'b1;
        wait_line();

        // reset in the middle of issuing
        r_prob = 0;
        start_line(1, 32'h3000_0000, 640);
        k = 0;
        while (ar_cnt - a0 < 2 && k < 200) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_arvalid_async", 32'(m_axi_arvalid), 0);
        chk("t6_ready_in_rst", 32'(line_data_ready), 0);
        exp_addr.delete(); exp_len.delete(); pend.delete(); tb_outst = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", 32'(line_data_ready), 1);
        chk("t6_busy_after", 32'(line_busy), 0);
        r_prob = 100;
        run_line(2, 32'h3000_0000, 100);

        for (int i = 0; i < 25; i++) begin
            ar_prob = $urandom_range(50, 100);
            r_prob  = $urandom_range(50, 100);
            rr_prob = $urandom_range(50, 100);
            en_prob = $urandom_range(70, 100);
            run_line($urandom_range(0, 2047), $urandom, $urandom_range(0, 400));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
